seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised, run-time programmable serial bit-sequence detector; successor to the fixed 4-state "1010" Mealy detector in the fsm library.
- Pattern (1..MAX_LEN bits), overlap vs non-overlap, and Mealy vs Moore output are all configurable at run time.
- Accepts qualified serial input (in_valid gaps allowed) and keeps a saturating match counter.
- Used as the generic sequence/sync-word detector in front of framing and protocol FSMs.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits, legal range 2..32.
- CNT_W, 8: width of the match_count saturating counter, legal range 1..32.
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len. Derived; must not be overridden.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  single-cycle strobe; latches the cfg_* inputs and clears history, fill and count.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] is received last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_moore  in  1  1 = registered (Moore) output, 0 = combinational (Mealy) output.
- in_valid  in  1  x is sampled only when this is high.
- x  in  1  serial data bit.
- match  out  1  match pulse.
- match_count  out  CNT_W  number of matches since reset or cfg_load; saturates.

Behaviour:
- Reset values:
  - Active registers: pat=0, len=1, overlap=1, moore=0, hist=0, fill=0, match_r=0, match_count=0.
  - Outputs during reset: match=0, match_count=0.
- Length clamp at cfg_load:
  - cfg_len=0 latches len=1.
  - cfg_len>MAX_LEN latches len=MAX_LEN.
  - Otherwise len=cfg_len.
- Accepted bit:
  - A bit is accepted when in_valid=1 and cfg_load=0.
  - If cfg_load and in_valid are high together, cfg_load wins and the bit is discarded.
- Next history (combinational):
  - hist_n = {hist[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, MAX_LEN).
- Hit (combinational): accepted bit AND fill_n >= len AND hist_n[len-1:0] == pat[len-1:0].
- On an accepted bit:
  - hist <= hist_n.
  - If hit and overlap=0: fill <= 0 (the history must refill fully before the next hit).
  - Otherwise: fill <= fill_n.
- Mealy mode (moore=0):
  - match = hit, combinational in the same cycle that x is presented.
  - Latency is 0 cycles.
- Moore mode (moore=1):
  - match_r <= hit every cycle; match = match_r.
  - The pulse is exactly one cycle, in the cycle after the accepting edge.
  - Back-to-back hits give back-to-back pulses.
- Mode change:
  - match_r is cleared on cfg_load.
  - In the cfg_load cycle match=0 in both modes.
- Match counter:
  - match_count <= match_count+1 at every edge where hit=1, in both modes.
  - Holds at 2^CNT_W-1 once reached; no wrap.
  - Cleared on cfg_load.
- Idle input: with in_valid=0, hist, fill and match_count hold, and Mealy match=0.
- Reset mid-stream: asynchronously returns all state to reset values; the partial pattern is lost.
- Equivalence: default configuration loaded with pattern 4'b1010, len 4, overlap 1, Mealy must produce the same cycle-exact output as the legacy 1010 overlapping Mealy detector for any stream with in_valid=1.

Decomposition:
- Package seq_detect_pkg holds:
  - default MAX_LEN and CNT_W;
  - function clamp_len(cfg_len, MAX_LEN);
  - constant SEQ_1010 = 4'b1010 for the benches.
- Sub-module sat_counter (parameters W; ports clk, rst_n, clr, inc, q):
  - saturating up-counter with synchronous clr;
  - reused for match_count.
- Everything else (history, fill, compare, output mux) lives in seq_detect_param.

Test Plan:
- Overlap, Mealy:
  - Stimulus: load pattern 1010, len=4, overlap=1, moore=0; stream 1,0,1,0,1,0,1 with in_valid=1.
  - Required: match=1 combinationally while the 4th and 6th bits are presented; match_count=2 afterwards.
- Non-overlap:
  - Stimulus: same pattern, overlap=0; stream 1,0,1,0,1,0,1,0.
  - Required: hits on the 4th and 8th bits only; match_count=2.
- Moore:
  - Stimulus: repeat test 1 with moore=1.
  - Required: match is high for one cycle after the 4th and 6th accepting edges; never combinational with x.
- in_valid gaps:
  - Stimulus: pattern 110, len=3; send 1,(gap×3),1,(gap),0.
  - Required: one hit on the final bit; during the gaps match=0 and count is unchanged.
- Saturation and length clamp:
  - Stimulus: CNT_W=2; load pattern 1 with cfg_len=0 (clamped to 1); send six 1s.
  - Required: match_count reads 1,2,3,3,3,3.
  - Stimulus: cfg_len=MAX_LEN+3.
  - Required: behaves as MAX_LEN.
- Reset and cfg_load mid-pattern:
  - Stimulus: after 1,0,1 of 1010, assert rst_n=0 asynchronously (between edges), then send 0.
  - Required: outputs drop to 0 immediately; no hit on the 0; the full 1,0,1,0 is needed again.
  - Stimulus: cfg_load together with the 4th bit.
  - Required: that bit is discarded, no hit, count=0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the programmable sequence detector.
package seq_detect_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  // Legacy sync word, kept here so benches and framing logic agree on it.
  localparam logic [3:0] SEQ_1010 = 4'b1010;

  // Map a requested pattern length onto the legal range 1..max_len.
  function automatic int clamp_len(input int cfg_len, input int max_len);
    if (cfg_len == 0)      return 1;
    if (cfg_len > max_len) return max_len;
    return cfg_len;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (inc && !(&cnt_q))   cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Run-time programmable serial sequence detector (overlap/non-overlap,
// Mealy/Moore output) with a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               in_valid,
  input  logic               x,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               moore_q, moore_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_r_q, match_r_d;

  logic               accept;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  // Selects the low len_q bits of history/pattern for the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (i < int'(len_q));
  end

  // Candidate history and hit detection; a load cycle never accepts a bit,
  // and hit is held low while in reset so match stays 0.
  always_comb begin
    accept = in_valid & ~cfg_load;
    hist_n = {hist_q[MAX_LEN-2:0], x};
    fill_n = (fill_q == MAX_LEN_L) ? fill_q : fill_q + 1'b1;
    hit    = rst_n & accept & (fill_n >= len_q) &
             ((hist_n & len_mask) == (pat_q & len_mask));
  end

  // Next-state: config latch on load, history/fill advance on accepted bits.
  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    moore_d   = moore_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_r_d = hit;
    if (cfg_load) begin
      pat_d     = cfg_pattern;
      len_d     = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      overlap_d = cfg_overlap;
      moore_d   = cfg_moore;
      hist_d    = '0;
      fill_d    = '0;
      match_r_d = 1'b0;
    end else if (accept) begin
      hist_d = hist_n;
      // Non-overlapping: force a full refill before the next hit can fire.
      fill_d = (hit && !overlap_q) ? '0 : fill_n;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '0;
      len_q     <= LEN_W'(1);
      overlap_q <= 1'b1;
      moore_q   <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      match_r_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      moore_q   <= moore_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_r_q <= match_r_d;
    end
  end

  // Output mux; a load cycle masks a stale Moore pulse as well.
  always_comb begin
    match = 1'b0;
    if (rst_n && !cfg_load) match = moore_q ? match_r_q : hit;
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cfg_load),
    .inc   (hit),
    .q     (match_count)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: stimulus pushes per-cycle expectations
// into a queue, a negedge monitor pops and compares match/match_count.
module tb_seq_detect_param;
  import seq_detect_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap, cfg_moore;
  logic               in_valid, x;
  logic               match;
  logic [CNT_W-1:0]   match_count;

  typedef struct {
    logic  m;
    int    cnt;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_moore   (cfg_moore),
    .in_valid    (in_valid),
    .x           (x),
    .match       (match),
    .match_count (match_count)
  );

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (match !== e.m || int'(match_count) != e.cnt) begin
        n_miss++;
        $display("FAIL %s: got match=%b count=%0d, want match=%b count=%0d",
                 e.nm, match, match_count, e.m, e.cnt);
      end
    end
  end

  function automatic void expect_cyc(input logic m, input int cnt, input string nm);
    exp_t e;
    e.m = m; e.cnt = cnt; e.nm = nm;
    sb.push_back(e);
  endfunction

  // One cycle of serial input with the expected outputs seen in that cycle.
  task automatic vec(input logic v, input logic b, input logic em, input int ec,
                     input string nm);
    @(posedge clk); #1;
    cfg_load = 1'b0; in_valid = v; x = b;
    expect_cyc(em, ec, nm);
  endtask

  // Load cycle; optional simultaneous in_valid bit (must be discarded).
  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic ov, input logic mo, input logic v, input logic b,
                      input int ec, input string nm);
    @(posedge clk); #1;
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l;
    cfg_overlap = ov; cfg_moore = mo; in_valid = v; x = b;
    expect_cyc(1'b0, ec, nm);
  endtask

  // Drive a bit list, MSB-first, with per-bit expected match and count.
  task automatic stream(input int n, input logic [15:0] bits, input logic [15:0] ms,
                        input int cnts[16], input string nm);
    for (int i = n - 1; i >= 0; i--)
      vec(1'b1, bits[i], ms[i], cnts[n-1-i], $sformatf("%s[%0d]", nm, n - 1 - i));
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_moore = 1'b0; in_valid = 1'b1; x = 1'b0;

    // Reset state: outputs low even with a bit that would match pat=0,len=1.
    @(posedge clk); #1; expect_cyc(1'b0, 0, "reset");
    @(posedge clk); #1; rst_n = 1'b1; in_valid = 1'b0; expect_cyc(1'b0, 0, "post_reset");

    // Overlap, Mealy: hits on 4th and 6th bits.
    load({4'b0, SEQ_1010}, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0, "ld_ovl");
    stream(7, 16'b1010101, 16'b0001010, '{0,0,0,0,1,1,2,0,0,0,0,0,0,0,0,0}, "ovl");
    vec(1'b0, 1'b0, 1'b0, 2, "ovl_idle");

    // Non-overlap: hits on 4th and 8th bits only.
    load({4'b0, SEQ_1010}, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2, "ld_novl");
    stream(8, 16'b10101010, 16'b00010001, '{0,0,0,0,1,1,1,1,0,0,0,0,0,0,0,0}, "novl");
    vec(1'b0, 1'b0, 1'b0, 2, "novl_idle");

    // Moore: pulse one cycle after the 4th and 6th accepting edges.
    load({4'b0, SEQ_1010}, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2, "ld_moore");
    stream(7, 16'b1010101, 16'b0000101, '{0,0,0,0,1,1,2,0,0,0,0,0,0,0,0,0}, "moore");
    vec(1'b0, 1'b0, 1'b0, 2, "moore_idle");

    // in_valid gaps, pattern 110: gap bits must not be sampled.
    load(8'b110, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2, "ld_gap");
    vec(1'b1, 1'b1, 1'b0, 0, "gap_b1");
    vec(1'b0, 1'b0, 1'b0, 0, "gap_g1");
    vec(1'b0, 1'b1, 1'b0, 0, "gap_g2");
    vec(1'b0, 1'b0, 1'b0, 0, "gap_g3");
    vec(1'b1, 1'b1, 1'b0, 0, "gap_b2");
    vec(1'b0, 1'b0, 1'b0, 0, "gap_g4");
    vec(1'b1, 1'b0, 1'b1, 0, "gap_b3");
    vec(1'b0, 1'b0, 1'b0, 1, "gap_idle");

    // Length 0 clamps to 1; counter saturates at 3.
    load(8'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, "ld_sat");
    stream(7, 16'b1111110, 16'b1111110, '{0,1,2,3,3,3,3,0,0,0,0,0,0,0,0,0}, "sat");
    vec(1'b0, 1'b0, 1'b0, 3, "sat_idle");

    // Length above MAX_LEN clamps to MAX_LEN: only the full 8-bit word hits.
    load(8'b10110011, 4'(MAX_LEN + 3), 1'b1, 1'b0, 1'b0, 1'b0, 3, "ld_clamp");
    stream(8, 16'b10110011, 16'b00000001, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, "clamp");
    vec(1'b0, 1'b0, 1'b0, 1, "clamp_idle");

    // Reset mid-pattern, asserted between edges.
    load({4'b0, SEQ_1010}, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1, "ld_rst");
    stream(7, 16'b1010101, 16'b0001000, '{0,0,0,0,1,1,1,0,0,0,0,0,0,0,0,0}, "prerst");
    @(posedge clk); #1; in_valid = 1'b1; x = 1'b0; #2; rst_n = 1'b0;
    expect_cyc(1'b0, 0, "rst_async");
    @(posedge clk); #1; expect_cyc(1'b0, 0, "rst_hold");
    @(posedge clk); #1; rst_n = 1'b1; in_valid = 1'b0; expect_cyc(1'b0, 0, "rst_rel");
    load({4'b0, SEQ_1010}, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0, "ld_after_rst");
    stream(5, 16'b01010, 16'b00001, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, "postrst");
    vec(1'b0, 1'b0, 1'b0, 1, "postrst_idle");

    // cfg_load with the 4th bit: bit discarded, count cleared, refill needed.
    load({4'b0, SEQ_1010}, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1, "ld_pre");
    stream(3, 16'b101, 16'b000, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, "prel");
    load({4'b0, SEQ_1010}, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 0, "ld_collide");
    vec(1'b0, 1'b0, 1'b0, 0, "collide_idle");
    stream(4, 16'b1010, 16'b0001, '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, "refill");
    vec(1'b0, 1'b0, 1'b0, 1, "refill_idle");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
